fifo_async_fwft: RTL and testbench

Next-generation dual-clock FIFO for packet-mover datapaths. It moves WIDTH-bit words from the wclk domain to the rclk domain using Gray-coded pointers through SYNC_STAGES-deep synchronisers. Over the previous generation it adds:
- a selectable first-word-fall-through (FWFT) read mode,
- fill-level outputs in both domains,
- programmable almost-full and almost-empty flags,
- overflow and underflow error pulses.

---
 rtl/fifo_async_fwft_pkg.sv | 24 ++
 rtl/fifo_async_fwft_gray_sync.sv | 34 +++
 rtl/fifo_async_fwft.sv | 168 ++++++++++++++++
 tb/tb_fifo_async_fwft.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_async_fwft_pkg.sv
// Shared helpers for the dual-clock FIFO: pointer sizing and Gray/binary conversion.
// Conversions work on a fixed 32-bit container; callers zero-extend and truncate.
package fifo_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_async_fwft_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the clk domain.
module gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_async_fwft.sv
// Dual-clock FIFO with Gray pointer crossings, fill levels, almost flags, error pulses
// and an optional first-word-fall-through output stage.
module fifo_async_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FWFT        = 0,
    parameter int AF_THRESH   = DEPTH - 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] wr_level,
    output logic                   wr_overflow,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] rd_level,
    output logic                   rd_underflow
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);
    localparam logic AF_RST = (AF_THRESH == 0);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "fifo_async_fwft: DEPTH must be a power of two >= 4");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $fatal(1, "fifo_async_fwft: SYNC_STAGES must be 2..4");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wbin_q, wbin_d, wgray_q, wgray_d, rgray_sync;
    logic [PTR_W-1:0] wr_level_q, wr_level_d;
    logic             full_q, full_d, af_q, af_d, wr_ovf_q, wr_ovf_d, push;

    logic [PTR_W-1:0] rbin_q, rbin_d, rgray_q, rgray_d, wgray_sync;
    logic [PTR_W-1:0] rd_level_q, rd_level_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             core_empty_q, core_empty_d, ae_q, ae_d, rd_udf_q, rd_udf_d;
    logic             out_valid_q, out_valid_d, rd_core, pop, lvl_adj, rd_empty;

    gray_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk(wclk), .rst_n(wrst_n), .d(rgray_q), .q(rgray_sync)
    );

    gray_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk(rclk), .rst_n(rrst_n), .d(wgray_q), .q(wgray_sync)
    );

    // Full when the next write pointer laps the synchronised read pointer by exactly DEPTH.
    always_comb begin
        push       = wr_en & ~full_q;
        wbin_d     = wbin_q + PTR_W'(push);
        wgray_d    = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_d)));
        full_d     = (wgray_d == {~rgray_sync[PTR_W-1:PTR_W-2], rgray_sync[PTR_W-3:0]});
        wr_level_d = wbin_d - PTR_W'(gray2bin(GRAY_MAX_W'(rgray_sync)));
        af_d       = (wr_level_d >= AF_LVL);
        wr_ovf_d   = wr_en & full_q;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            full_q     <= 1'b0;
            af_q       <= AF_RST;
            wr_level_q <= '0;
            wr_ovf_q   <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            full_q     <= full_d;
            af_q       <= af_d;
            wr_level_q <= wr_level_d;
            wr_ovf_q   <= wr_ovf_d;
        end
    end

    always_ff @(posedge wclk) begin
        if (push) begin
            mem[wbin_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign pop = rd_core & ~core_empty_q;

    // FWFT keeps the output register topped up from the core whenever it is free or being consumed.
    if (FWFT != 0) begin : g_fwft
        assign rd_core = ~out_valid_q | rd_en;
        always_comb begin
            out_valid_d = out_valid_q;
            if (rd_en && out_valid_q) begin
                out_valid_d = 1'b0;
            end
            if (pop) begin
                out_valid_d = 1'b1;
            end
            lvl_adj  = out_valid_d;
            rd_empty = ~out_valid_q;
        end
    end else begin : g_std
        assign rd_core = rd_en;
        always_comb begin
            out_valid_d = pop;
            lvl_adj     = 1'b0;
            rd_empty    = core_empty_q;
        end
    end

    always_comb begin
        rbin_d       = rbin_q + PTR_W'(pop);
        rgray_d      = PTR_W'(bin2gray(GRAY_MAX_W'(rbin_d)));
        core_empty_d = (rgray_d == wgray_sync);
        rd_level_d   = PTR_W'(gray2bin(GRAY_MAX_W'(wgray_sync))) - rbin_d + PTR_W'(lvl_adj);
        ae_d         = (rd_level_d <= AE_LVL);
        rd_data_d    = pop ? mem[rbin_q[ADDR_W-1:0]] : rd_data_q;
        rd_udf_d     = rd_en & rd_empty;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rgray_q      <= '0;
            core_empty_q <= 1'b1;
            rd_level_q   <= '0;
            ae_q         <= 1'b1;
            rd_data_q    <= '0;
            out_valid_q  <= 1'b0;
            rd_udf_q     <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rgray_q      <= rgray_d;
            core_empty_q <= core_empty_d;
            rd_level_q   <= rd_level_d;
            ae_q         <= ae_d;
            rd_data_q    <= rd_data_d;
            out_valid_q  <= out_valid_d;
            rd_udf_q     <= rd_udf_d;
        end
    end

    assign full         = full_q;
    assign almost_full  = af_q;
    assign wr_level     = wr_level_q;
    assign wr_overflow  = wr_ovf_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = out_valid_q;
    assign empty        = rd_empty;
    assign almost_empty = ae_q;
    assign rd_level     = rd_level_q;
    assign rd_underflow = rd_udf_q;

endmodule

// File: tb/tb_fifo_async_fwft.sv
// Directed bench for fifo_async_fwft: instance 0 is the registered-read FIFO, instance 1 the FWFT one.
// Each comparison is an immediate assertion; a streaming phase checks ordering with a scoreboard.
`timescale 1ns/1ps
module tb_fifo_async_fwft;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    realtime whalf = 5.0;
    realtime rhalf = 13.5;
    logic    wclk  = 1'b0;
    logic    rclk  = 1'b0;
    logic    wrst_n, rrst_n;

    always #(whalf) wclk = ~wclk;
    always #(rhalf) rclk = ~rclk;

    logic             wr_en        [2];
    logic [WIDTH-1:0] wr_data      [2];
    logic             full         [2];
    logic             almost_full  [2];
    logic [4:0]       wr_level     [2];
    logic             wr_overflow  [2];
    logic             rd_en        [2];
    logic [WIDTH-1:0] rd_data      [2];
    logic             rd_valid     [2];
    logic             empty        [2];
    logic             almost_empty [2];
    logic [4:0]       rd_level     [2];
    logic             rd_underflow [2];

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [WIDTH-1:0] sb0 [$];
    logic [WIDTH-1:0] sb1 [$];

    fifo_async_fwft #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)
    ) u_std (
        .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n),
        .wr_en(wr_en[0]), .wr_data(wr_data[0]), .full(full[0]), .almost_full(almost_full[0]),
        .wr_level(wr_level[0]), .wr_overflow(wr_overflow[0]),
        .rd_en(rd_en[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .empty(empty[0]),
        .almost_empty(almost_empty[0]), .rd_level(rd_level[0]), .rd_underflow(rd_underflow[0])
    );

    fifo_async_fwft #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)
    ) u_fwft (
        .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n),
        .wr_en(wr_en[1]), .wr_data(wr_data[1]), .full(full[1]), .almost_full(almost_full[1]),
        .wr_level(wr_level[1]), .wr_overflow(wr_overflow[1]),
        .rd_en(rd_en[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .empty(empty[1]),
        .almost_empty(almost_empty[1]), .rd_level(rd_level[1]), .rd_underflow(rd_underflow[1])
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input int d);
        check_output("rst_full",         32'(full[d]),         32'd0);
        check_output("rst_almost_full",  32'(almost_full[d]),  32'd0);
        check_output("rst_wr_level",     32'(wr_level[d]),     32'd0);
        check_output("rst_wr_overflow",  32'(wr_overflow[d]),  32'd0);
        check_output("rst_empty",        32'(empty[d]),        32'd1);
        check_output("rst_rd_valid",     32'(rd_valid[d]),     32'd0);
        check_output("rst_almost_empty", 32'(almost_empty[d]), 32'd1);
        check_output("rst_rd_level",     32'(rd_level[d]),     32'd0);
        check_output("rst_rd_data",      rd_data[d],           32'd0);
        check_output("rst_rd_underflow", 32'(rd_underflow[d]), 32'd0);
    endtask

    task automatic apply_reset();
        for (int d = 0; d < 2; d++) begin
            wr_en[d] = 1'b0;
            rd_en[d] = 1'b0;
        end
        wrst_n = 1'b0;
        rrst_n = 1'b0;
        repeat (3) @(posedge wclk);
        @(posedge rclk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge wclk);
        wrst_n = 1'b1;
        rrst_n = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
    endtask

    task automatic write_word(input int d, input logic [31:0] data);
        @(negedge wclk);
        wr_en[d]   = 1'b1;
        wr_data[d] = data;
        @(posedge wclk);
        #1;
        wr_en[d] = 1'b0;
    endtask

    task automatic read_word(input int d);
        @(negedge rclk);
        rd_en[d] = 1'b1;
        @(posedge rclk);
        #1;
        rd_en[d] = 1'b0;
    endtask

    task automatic wait_rclk(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic wait_not_empty(input int d, input int budget);
        int k = 0;
        while (empty[d] && k < budget) begin
            @(posedge rclk);
            #1;
            k++;
        end
        check_output("wait_not_empty_timeout", 32'(empty[d]), 32'd0);
    endtask

    function automatic logic [31:0] sb_pop(input int d);
        logic [31:0] v;
        v = 32'hxxxx_xxxx;
        if (d == 0) begin
            if (sb0.size() > 0) v = sb0.pop_front();
        end else begin
            if (sb1.size() > 0) v = sb1.pop_front();
        end
        return v;
    endfunction

    task automatic stream_writer(input int d, input int n);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 20000) begin
            @(posedge wclk);
            #1;
            cyc++;
            check_output("stream_no_overflow", 32'(wr_overflow[d]), 32'd0);
            check_output("stream_wr_level_bound", 32'(wr_level[d] <= 5'd16), 32'd1);
            wr_en[d] = 1'b0;
            if (!full[d] && $urandom_range(3) != 0) begin
                wr_data[d] = $urandom;
                wr_en[d]   = 1'b1;
                if (d == 0) sb0.push_back(wr_data[d]);
                else        sb1.push_back(wr_data[d]);
                sent++;
            end
        end
        @(posedge wclk);
        #1;
        wr_en[d] = 1'b0;
        check_output("stream_writer_done", 32'(sent), 32'(n));
    endtask

    task automatic stream_reader(input int d, input int n);
        int got = 0;
        int cyc = 0;
        logic [31:0] exp;
        while (got < n && cyc < 40000) begin
            @(posedge rclk);
            #1;
            cyc++;
            check_output("stream_no_underflow", 32'(rd_underflow[d]), 32'd0);
            rd_en[d] = 1'b0;
            if (d == 0) begin
                if (rd_valid[d]) begin
                    exp = sb_pop(0);
                    check_output("stream_std_data", rd_data[d], exp);
                    got++;
                end
                if (!empty[d] && $urandom_range(2) != 0) rd_en[d] = 1'b1;
            end else begin
                if (rd_valid[d] && $urandom_range(2) != 0) begin
                    exp = sb_pop(1);
                    check_output("stream_fwft_data", rd_data[d], exp);
                    got++;
                    rd_en[d] = 1'b1;
                end
            end
        end
        @(posedge rclk);
        #1;
        rd_en[d] = 1'b0;
        check_output("stream_reader_done", 32'(got), 32'(n));
    endtask

    task automatic run_stream(input int n);
        apply_reset();
        release_reset();
        fork
            stream_writer(0, n);
            stream_reader(0, n);
            stream_writer(1, n);
            stream_reader(1, n);
        join
        repeat (10) @(posedge wclk);
        repeat (10) @(posedge rclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_output("stream_end_empty",    32'(empty[d]),    32'd1);
            check_output("stream_end_rd_level", 32'(rd_level[d]), 32'd0);
            check_output("stream_end_wr_level", 32'(wr_level[d]), 32'd0);
        end
        check_output("stream_sb0_drained", 32'(sb0.size()), 32'd0);
        check_output("stream_sb1_drained", 32'(sb1.size()), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_data[d] = '0;
        end

        // Reset values on both variants.
        apply_reset();
        release_reset();
        check_reset_values(0);
        check_reset_values(1);

        // Fill: almost_full after the 14th push, full after the 16th, then an overflow.
        for (int i = 0; i < 16; i++) begin
            write_word(0, 32'(i));
            if (i == 12) begin
                check_output("fill_af_before", 32'(almost_full[0]), 32'd0);
                check_output("fill_level_13",  32'(wr_level[0]),    32'd13);
            end
            if (i == 13) begin
                check_output("fill_af_at_14", 32'(almost_full[0]), 32'd1);
                check_output("fill_not_full", 32'(full[0]),        32'd0);
            end
            if (i == 15) begin
                check_output("fill_full",     32'(full[0]),     32'd1);
                check_output("fill_level_16", 32'(wr_level[0]), 32'd16);
            end
        end
        write_word(0, 32'hDEAD);
        check_output("overflow_pulse",   32'(wr_overflow[0]), 32'd1);
        check_output("overflow_level",   32'(wr_level[0]),    32'd16);
        @(posedge wclk);
        #1;
        check_output("overflow_one_cycle", 32'(wr_overflow[0]), 32'd0);

        // Drain in order with single-cycle rd_valid, then an underflow.
        wait_rclk(5);
        check_output("drain_rd_level_16", 32'(rd_level[0]),     32'd16);
        check_output("drain_not_ae",      32'(almost_empty[0]), 32'd0);
        check_output("drain_not_empty",   32'(empty[0]),        32'd0);
        for (int i = 0; i < 16; i++) begin
            read_word(0);
            check_output("drain_valid", 32'(rd_valid[0]), 32'd1);
            check_output("drain_data",  rd_data[0],       32'(i));
            if (i == 15) begin
                check_output("drain_empty_after_last", 32'(empty[0]),        32'd1);
                check_output("drain_rd_level_0",       32'(rd_level[0]),     32'd0);
                check_output("drain_ae_after_last",    32'(almost_empty[0]), 32'd1);
            end
            wait_rclk(1);
            check_output("drain_valid_drop", 32'(rd_valid[0]), 32'd0);
            check_output("drain_data_hold",  rd_data[0],       32'(i));
        end
        read_word(0);
        check_output("underflow_pulse",     32'(rd_underflow[0]), 32'd1);
        check_output("underflow_data_hold", rd_data[0],           32'd15);
        check_output("underflow_no_valid",  32'(rd_valid[0]),     32'd0);
        wait_rclk(1);
        check_output("underflow_one_cycle", 32'(rd_underflow[0]), 32'd0);
        repeat (6) @(posedge wclk);
        #1;
        check_output("drain_full_release", 32'(full[0]),     32'd0);
        check_output("drain_wr_level_0",   32'(wr_level[0]), 32'd0);

        // FWFT: word falls through on the fourth rclk edge after the write edge.
        write_word(1, 32'hA5A5_A5A5);
        wait_rclk(3);
        check_output("fwft_not_yet_valid", 32'(rd_valid[1]), 32'd0);
        wait_rclk(1);
        check_output("fwft_valid",    32'(rd_valid[1]), 32'd1);
        check_output("fwft_data",     rd_data[1],       32'hA5A5_A5A5);
        check_output("fwft_level_1",  32'(rd_level[1]), 32'd1);
        check_output("fwft_nonempty", 32'(empty[1]),    32'd0);
        read_word(1);
        check_output("fwft_empty_after_pop", 32'(empty[1]),    32'd1);
        check_output("fwft_level_0",         32'(rd_level[1]), 32'd0);
        check_output("fwft_valid_drop",      32'(rd_valid[1]), 32'd0);
        check_output("fwft_data_hold",       rd_data[1],       32'hA5A5_A5A5);

        // Reset mid-transfer discards queued words.
        for (int i = 0; i < 5; i++) begin
            write_word(0, 32'h100 + 32'(i));
        end
        wait_rclk(1);
        apply_reset();
        check_reset_values(0);
        release_reset();
        check_reset_values(0);
        write_word(0, 32'h1234);
        wait_not_empty(0, 10);
        read_word(0);
        check_output("post_reset_valid", 32'(rd_valid[0]), 32'd1);
        check_output("post_reset_data",  rd_data[0],       32'h1234);
        check_output("post_reset_empty", 32'(empty[0]),    32'd1);

        // Levels with three resident words, then one pop.
        write_word(0, 32'h61);
        write_word(0, 32'h62);
        write_word(0, 32'h63);
        wait_rclk(6);
        check_output("lvl_wr_3",    32'(wr_level[0]),     32'd3);
        check_output("lvl_rd_3",    32'(rd_level[0]),     32'd3);
        check_output("lvl_ae_off",  32'(almost_empty[0]), 32'd0);
        read_word(0);
        check_output("lvl_pop_data", rd_data[0],           32'h61);
        check_output("lvl_rd_2",     32'(rd_level[0]),     32'd2);
        check_output("lvl_ae_on",    32'(almost_empty[0]), 32'd1);
        wait_rclk(4);
        check_output("lvl_wr_2",     32'(wr_level[0]),     32'd2);

        // Streaming with random handshakes at both clock ratios.
        run_stream(1000);
        whalf = 13.5;
        rhalf = 5.0;
        run_stream(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
